// File: rtl/loader_pkg.sv
// Program loader shared types and constants.
// State encoding and image geometry used by the loader and its sub-block.
package loader_pkg;

  localparam int ADDR_W    = 10;
  localparam int WORD_W    = 16;
  localparam int MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Word assembler: pairs stream bytes into instruction words.
// Ports: clk, rst (sync, high), clr (re-arm), hi_en/lo_en byte strobes,
// data byte in; wr_en/wr_addr/wr_data instruction-memory write port.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [7:0]        data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data
);

  logic [7:0] hi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= lo_en;
      if (hi_en)
        hi_q <= data;
      if (lo_en)
        wr_data <= {hi_q, data};
      // Address advances after the pulse, so it shows the
      // current word index while wr_en is high; wraps at 2**ADDR_W.
      if (clr)
        wr_addr <= '0;
      else if (wr_en)
        wr_addr <= wr_addr + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> instruction memory.
// Ports: clk, rst (sync, high); inData/inValid/inReady byte handshake;
// reload re-arm pulse; imWr* memory write port; cpuRst, done, err status.
module prog_loader
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        inData,
  input  logic              inValid,
  output logic              inReady,
  input  logic              reload,
  output logic              imWrEn,
  output logic [ADDR_W-1:0] imWrAddr,
  output logic [WORD_W-1:0] imWrData,
  output logic              cpuRst,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] wcnt_q;
  logic [7:0]  csum_q;
  logic [15:0] hdr_cnt;
  logic        accept;
  logic        rearm;
  logic        last_word;

  assign inReady = (state_q != DONE) && (state_q != ERR);
  assign accept  = inValid & inReady;
  assign rearm   = reload & ((state_q == DONE) || (state_q == ERR));
  assign hdr_cnt = {cnt_q[15:8], inData};
  // Only evaluated in DAT_LO, where count is known to be >= 1.
  assign last_word = (wcnt_q == cnt_q - 16'd1);

  assign cpuRst = (state_q != DONE);
  assign done   = (state_q == DONE);
  assign err    = (state_q == ERR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_HI:
        if (accept) state_d = HDR_LO;
      HDR_LO:
        if (accept) begin
          if (hdr_cnt > MAX_CNT)
            state_d = ERR;
          else if (hdr_cnt == 16'd0)
            state_d = CSUM;
          else
            state_d = DAT_HI;
        end
      DAT_HI:
        if (accept) state_d = DAT_LO;
      DAT_LO:
        if (accept) state_d = last_word ? CSUM : DAT_HI;
      CSUM:
        if (accept)
          state_d = (inData == csum_q) ? DONE : ERR;
      DONE, ERR:
        if (reload) state_d = HDR_HI;
      default:
        state_d = HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR_HI;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rearm) begin
        cnt_q  <= '0;
        wcnt_q <= '0;
        csum_q <= '0;
      end else if (accept) begin
        if (state_q != CSUM)
          csum_q <= csum_q ^ inData;
        if (state_q == HDR_HI)
          cnt_q[15:8] <= inData;
        if (state_q == HDR_LO)
          cnt_q[7:0] <= inData;
        if (state_q == DAT_LO)
          wcnt_q <= wcnt_q + 16'd1;
      end
    end
  end

  word_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (rearm),
    .hi_en   (accept && (state_q == DAT_HI)),
    .lo_en   (accept && (state_q == DAT_LO)),
    .data    (inData),
    .wr_en   (imWrEn),
    .wr_addr (imWrAddr),
    .wr_data (imWrData)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed streams, write scoreboard.
// Expected writes are queued at stimulus time and popped by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        reload;
  logic        imWrEn;
  logic [9:0]  imWrAddr;
  logic [15:0] imWrData;
  logic        cpuRst;
  logic        done;
  logic        err;

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef logic [7:0] bq_t[$];

  wr_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .inData   (inData),
    .inValid  (inValid),
    .inReady  (inReady),
    .reload   (reload),
    .imWrEn   (imWrEn),
    .imWrAddr (imWrAddr),
    .imWrData (imWrData),
    .cpuRst   (cpuRst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Monitor: compares every write pulse against the scoreboard.
  always @(negedge clk) begin
    if (imWrEn) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                 imWrAddr, imWrData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imWrAddr !== e.a || imWrData !== e.d) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                   imWrAddr, imWrData, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    int n;
    inData  = b;
    inValid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      acc = inReady;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: byte %h not accepted in 20 cycles", b);
    end
    if (gap) begin
      inValid = 1'b0;
      step(1);
    end
  endtask

  // Sends all bytes; checks core is still held in reset before the last.
  task automatic send_stream(input bq_t s, input bit gap, input string tag);
    for (int i = 0; i < s.size(); i++) begin
      if (i == s.size() - 1) begin
        chk({tag, "_cpuRst_loading"}, 32'(cpuRst), 32'd1);
        chk({tag, "_done_loading"}, 32'(done), 32'd0);
      end
      send_byte(s[i], gap);
    end
    inValid = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input bq_t s);
    logic [7:0] x = 8'h00;
    foreach (s[i]) x ^= s[i];
    return x;
  endfunction

  task automatic do_reset();
    inValid = 1'b0;
    reload  = 1'b0;
    rst     = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    step(1);
    reload = 1'b0;
    chk({tag, "_rl_done"}, 32'(done), 32'd0);
    chk({tag, "_rl_err"}, 32'(err), 32'd0);
    chk({tag, "_rl_cpuRst"}, 32'(cpuRst), 32'd1);
    chk({tag, "_rl_inReady"}, 32'(inReady), 32'd1);
  endtask

  task automatic end_ok(input string tag, input logic d, input logic e);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_cpuRst"}, 32'(cpuRst), 32'(!d));
    chk({tag, "_inReady"}, 32'(inReady), 32'd0);
    step(3);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bq_t s;
    logic [7:0] cs;

    rst     = 1'b1;
    inData  = 8'h00;
    inValid = 1'b0;
    reload  = 1'b0;
    step(2);
    do_reset();

    chk("rst_inReady", 32'(inReady), 32'd1);
    chk("rst_cpuRst", 32'(cpuRst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrEn", 32'(imWrEn), 32'd0);
    chk("rst_wrAddr", 32'(imWrAddr), 32'd0);
    chk("rst_wrData", 32'(imWrData), 32'd0);

    // Nominal two-word image; checksum of these bytes is 0x42.
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    push_wr(10'd0, 16'h1234);
    push_wr(10'd1, 16'hABCD);
    send_stream(s, 1'b0, "nom");
    end_ok("nom", 1'b1, 1'b0);

    // Reload with a byte offered in the same cycle: must not be consumed.
    inData  = 8'h7F;
    inValid = 1'b1;
    do_reload("rl1");
    inValid = 1'b0;
    s  = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    cs = xsum(s);
    s.push_back(cs);
    push_wr(10'd0, 16'hBEEF);
    send_stream(s, 1'b0, "beef");
    end_ok("beef", 1'b1, 1'b0);

    // Bad checksum.
    do_reload("rl2");
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    push_wr(10'd0, 16'h1234);
    push_wr(10'd1, 16'hABCD);
    send_stream(s, 1'b0, "badcs");
    end_ok("badcs", 1'b0, 1'b1);

    // Empty image.
    do_reload("rl3");
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 1'b0, "empty");
    end_ok("empty", 1'b0 ^ 1'b1, 1'b0);

    // Oversize header (1025 words) errors right after the second byte.
    do_reload("rl4");
    s = '{8'h04, 8'h01};
    send_stream(s, 1'b0, "big");
    end_ok("big", 1'b0, 1'b1);

    // Nominal stream with a bubble after every byte.
    do_reload("rl5");
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    push_wr(10'd0, 16'h1234);
    push_wr(10'd1, 16'hABCD);
    send_stream(s, 1'b1, "gap");
    end_ok("gap", 1'b1, 1'b0);

    // Reset after a high data byte: no write, loader back at header.
    do_reload("rl6");
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hBE, 1'b0);
    do_reset();
    chk("mid_inReady", 32'(inReady), 32'd1);
    chk("mid_cpuRst", 32'(cpuRst), 32'd1);
    chk("mid_wrAddr", 32'(imWrAddr), 32'd0);
    step(3);
    s  = '{8'h00, 8'h01, 8'h12, 8'h34};
    cs = xsum(s);
    s.push_back(cs);
    push_wr(10'd0, 16'h1234);
    send_stream(s, 1'b0, "post");
    end_ok("post", 1'b1, 1'b0);

    // Full 1024-word image, word i = i.
    do_reload("rl7");
    s = '{8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      s.push_back(8'(i >> 8));
      s.push_back(8'(i));
      push_wr(10'(i), 16'(i));
    end
    cs = xsum(s);
    s.push_back(cs);
    send_stream(s, 1'b0, "full");
    end_ok("full", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
